sasc_tx_ser: RTL and testbench
==============================

Name: sasc_tx_ser

Overview:
- Serial transmit engine for the simple async serial controller.
- Reader side of the 4-entry TX FIFO: pops bytes through the FIFO's `empty`/`re`/`dout` interface and serialises each one onto `txd_o` as an async frame: start bit, 8 data bits LSB first, stop bit.
- Bit timing comes from an external one-cycle baud enable `sio_ce`.
- Flow control via the CTS input.

Parameters:
- None. Frame format is fixed: 8 data bits, 1 stop bit.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear; aborts any frame, returns to idle
- sio_ce  input  1  baud tick; one-cycle pulse per bit period
- cts_i  input  1  clear-to-send, active high; gates new FIFO pops only
- fifo_empty  input  1  TX FIFO empty flag
- fifo_dout  input  8  TX FIFO head data, combinationally valid while `fifo_empty`=0
- fifo_re  output  1  FIFO read strobe; one-cycle pulse per byte
- txd_o  output  1  serial data out; idle/mark = 1
- busy_o  output  1  high while a byte is held or a frame is in progress

Behaviour:
- Reset (`rst`=0, async):
  - state=IDLE, `txd_o`=1, `hold_v`=0, bit counter=0, `busy_o`=0, `fifo_re`=0.
- Holding register `hold[7:0]` with valid flag `hold_v` decouples FIFO pops from bit timing.
- `fifo_re` (combinational):
  - `fifo_re` = (state==IDLE | state==STOP) & !`hold_v` & !`fifo_empty` & `cts_i` & !`clr`.
  - On that edge: `hold`<=`fifo_dout`, `hold_v`<=1.
  - Never asserted when `fifo_empty`=1.
  - At most one pop per byte; never two consecutive cycles, because `hold_v` blocks the second.
- States: IDLE, START, DATA, STOP. Transitions happen only on cycles with `sio_ce`=1, except `clr`/reset.
  - IDLE: `txd_o`=1. On `sio_ce` & `hold_v`: shift<=`hold`, `hold_v`<=0, `txd_o`<=0, go START.
  - START: on `sio_ce`: `txd_o`<=shift[0], shift>>=1, bitcnt<=1, go DATA.
  - DATA: on `sio_ce`:
    - if bitcnt==8: `txd_o`<=1, go STOP;
    - else: `txd_o`<=shift[0], shift>>=1, bitcnt++.
  - STOP: `txd_o`=1; prefetch pop allowed. On `sio_ce`:
    - if `hold_v`: load next byte, `txd_o`<=0, go START (back-to-back);
    - else: go IDLE.
- Latency and timing:
  - A byte popped in IDLE starts its start bit on the next `sio_ce` after the pop edge.
  - Each bit lasts exactly one `sio_ce` period.
  - Continuous streaming gives 10 ticks per frame, with no idle gap if the FIFO stays non-empty.
- `busy_o` = (state!=IDLE) | `hold_v`, registered-equivalent; 0 only when fully idle.
- CTS:
  - Deassertion never truncates a frame in progress.
  - Deassertion does not discard an already-held byte; that byte is still transmitted.
  - Deassertion only blocks further pops.
- `clr` (sync, highest priority after reset):
  - state=IDLE, `txd_o`=1, `hold_v`=0, bitcnt=0.
  - A byte in `hold` is discarded.
  - `fifo_re`=0 in the `clr` cycle.
- `sio_ce` and a pop in the same cycle while in IDLE with `hold_v`=0: pop only; the frame starts on the next tick.

Optional Feature:
- Macro: `SASC_TX_PARITY_EN`.
- Defined:
  - Adds state PAR between DATA and STOP.
  - On the tick ending bit 8, `txd_o`<=even parity (XOR of the 8 data bits, latched at load), go PAR.
  - Next tick: `txd_o`<=1, go STOP.
  - Frame = 11 ticks.
- Undefined:
  - No PAR state, no parity logic; frame = 10 ticks.

Test Plan:
- Reset: `rst`=0 mid-frame -> `txd_o`=1, `busy_o`=0, `fifo_re`=0 immediately. After release with `fifo_empty`=1, outputs stay idle indefinitely.
- Single byte 0xA5, `sio_ce` every 4 clk, `cts_i`=1:
  - exactly one `fifo_re` pulse;
  - `txd_o` sequence per tick = 0,1,0,1,0,0,1,0,1,1;
  - `busy_o` falls after the stop tick.
- Back-to-back 0x00 then 0xFF pre-loaded in FIFO -> 20 consecutive bit periods: 0,00000000,1,0,11111111,1, with no extra idle tick; exactly two `fifo_re` pulses.
- CTS: `cts_i`=0 with FIFO non-empty -> no `fifo_re`, `txd_o`=1. Drop `cts_i` mid-frame of 0x3C -> frame completes intact and no further pop occurs.
- `clr` asserted during DATA bit 4 -> next cycle `txd_o`=1, state idle, held byte dropped, no `fifo_re` in the `clr` cycle.
- With `SASC_TX_PARITY_EN`: byte 0x07 -> parity bit 1, frame 0,1,1,1,0,0,0,0,0,1,1 (11 ticks). Byte 0x03 -> parity bit 0.

Source files
------------

// File: rtl/sasc_tx_ser.sv
// Serial transmit engine: pops bytes from the TX FIFO and sends start, 8 data bits LSB first, stop.
// Define SASC_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module sasc_tx_ser (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       sio_ce,
    input  logic       cts_i,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_re,
    output logic       txd_o,
    output logic       busy_o
);

`ifdef SASC_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        PAR   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    state_t     state, state_nxt;
    logic [7:0] hold, hold_nxt;
    logic       hold_v, hold_v_nxt;
    logic [7:0] shift, shift_nxt;
    logic [3:0] bitcnt, bitcnt_nxt;
    logic       txd_nxt;
`ifdef SASC_TX_PARITY_EN
    logic       par, par_nxt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            hold   <= '0;
            hold_v <= 1'b0;
            shift  <= '0;
            bitcnt <= '0;
            txd_o  <= 1'b1;
`ifdef SASC_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            hold   <= hold_nxt;
            hold_v <= hold_v_nxt;
            shift  <= shift_nxt;
            bitcnt <= bitcnt_nxt;
            txd_o  <= txd_nxt;
`ifdef SASC_TX_PARITY_EN
            par    <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold;
        hold_v_nxt = hold_v;
        shift_nxt  = shift;
        bitcnt_nxt = bitcnt;
        txd_nxt    = txd_o;
`ifdef SASC_TX_PARITY_EN
        par_nxt    = par;
`endif

        // Pop is gated by rst so no strobe leaks out while the block is held in reset
        fifo_re = rst & ~clr & ~hold_v & ~fifo_empty & cts_i &
                  ((state == IDLE) | (state == STOP));

        if (fifo_re) begin
            hold_nxt   = fifo_dout;
            hold_v_nxt = 1'b1;
        end

        if (sio_ce) begin
            case (state)
                IDLE: begin
                    if (hold_v) begin
                        shift_nxt  = hold;
                        hold_v_nxt = 1'b0;
                        txd_nxt    = 1'b0;
                        state_nxt  = START;
`ifdef SASC_TX_PARITY_EN
                        par_nxt    = ^hold;
`endif
                    end
                end
                START: begin
                    txd_nxt    = shift[0];
                    shift_nxt  = {1'b0, shift[7:1]};
                    bitcnt_nxt = 4'd1;
                    state_nxt  = DATA;
                end
                DATA: begin
                    if (bitcnt == 4'd8) begin
`ifdef SASC_TX_PARITY_EN
                        txd_nxt   = par;
                        state_nxt = PAR;
`else
                        txd_nxt   = 1'b1;
                        state_nxt = STOP;
`endif
                    end else begin
                        txd_nxt    = shift[0];
                        shift_nxt  = {1'b0, shift[7:1]};
                        bitcnt_nxt = bitcnt + 4'd1;
                    end
                end
`ifdef SASC_TX_PARITY_EN
                PAR: begin
                    txd_nxt   = 1'b1;
                    state_nxt = STOP;
                end
`endif
                STOP: begin
                    // A byte prefetched during the stop bit starts immediately: no idle tick
                    if (hold_v) begin
                        shift_nxt  = hold;
                        hold_v_nxt = 1'b0;
                        txd_nxt    = 1'b0;
                        state_nxt  = START;
`ifdef SASC_TX_PARITY_EN
                        par_nxt    = ^hold;
`endif
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    txd_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            endcase
        end

        if (clr) begin
            state_nxt  = IDLE;
            txd_nxt    = 1'b1;
            hold_v_nxt = 1'b0;
            bitcnt_nxt = '0;
        end
    end

    assign busy_o = (state != IDLE) | hold_v;

endmodule

// File: tb/tb_sasc_tx_ser.sv
// Bench for sasc_tx_ser: queue-backed FIFO model and a frame-level reference of the expected line.
`timescale 1ns/1ps
module tb_sasc_tx_ser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       sio_ce = 1'b0;
    logic       cts_i = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = '0;
    logic       fifo_re, txd_o, busy_o;

    sasc_tx_ser dut (
        .clk(clk), .rst(rst), .clr(clr), .sio_ce(sio_ce), .cts_i(cts_i),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_re(fifo_re), .txd_o(txd_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0, n_err = 0;
    logic [7:0]  fq[$];
    logic [7:0]  popped[$];
    logic [7:0]  sent[$];
    logic        ticks[$];
    logic        tbusy[$];
    logic        exp_bits[$];
    int unsigned ce_per = 4, cyc = 0, pops = 0, bad_empty = 0, dbl = 0, clr_re = 0;
    logic        prev_re = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, observe strobe, then record the line value on baud ticks.
    task automatic step(input logic clr_v);
        logic ce_now;
        @(negedge clk);
        clr        = clr_v;
        sio_ce     = (cyc % ce_per) == (ce_per - 1);
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? 8'h00 : fq[0];
        cyc++;
        #1;
        if (fifo_re === 1'b1) begin
            pops++;
            if (fifo_empty) bad_empty++;
            else popped.push_back(fq.pop_front());
            if (prev_re === 1'b1) dbl++;
            if (clr_v) clr_re++;
        end
        prev_re = fifo_re;
        ce_now  = sio_ce;
        @(posedge clk);
        #1;
        if (ce_now) begin
            ticks.push_back(txd_o);
            tbusy.push_back(busy_o);
        end
    endtask

    task automatic trk_clear();
        ticks.delete(); tbusy.delete(); popped.delete(); sent.delete();
        pops = 0; bad_empty = 0; dbl = 0; clr_re = 0;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        sent.push_back(b);
    endtask

    function automatic int unsigned zeros_from(input int unsigned from);
        int unsigned z = 0;
        for (int unsigned i = from; i < ticks.size(); i++)
            if (ticks[i] !== 1'b1) z++;
        return z;
    endfunction

    function automatic int unsigned since_start();
        for (int unsigned i = 0; i < ticks.size(); i++)
            if (ticks[i] === 1'b0) return ticks.size() - i;
        return 0;
    endfunction

    task automatic run_idle(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while ((fq.size() != 0 || busy_o !== 1'b0 || n < 4) && n < budget) begin
            step(1'b0);
            n++;
        end
        chk({tag, "_done"}, n < budget, 1);
        repeat (3 * ce_per) step(1'b0);
    endtask

    // Expected line: every sent byte framed back to back, idle mark everywhere else.
    task automatic check_frames(input string tag);
        int unsigned k = 0;
        int unsigned len;
        exp_bits.delete();
        foreach (sent[i]) begin
            exp_bits.push_back(1'b0);
            for (int unsigned j = 0; j < 8; j++) exp_bits.push_back(sent[i][j]);
`ifdef SASC_TX_PARITY_EN
            exp_bits.push_back(^sent[i]);
`endif
            exp_bits.push_back(1'b1);
        end
        while (k < ticks.size() && ticks[k] === 1'b1) k++;
        len = exp_bits.size();
        chk({tag, "_nticks"}, ticks.size() >= k + len + 1, 1);
        for (int unsigned i = 0; i < len; i++)
            if (k + i < ticks.size())
                chk($sformatf("%s_bit%0d", tag, i), ticks[k + i], exp_bits[i]);
        chk({tag, "_trail"}, zeros_from(k + len), 0);
        if (len > 0 && k + len < tbusy.size()) begin
            chk({tag, "_busy_last"}, tbusy[k + len - 1], 1);
            chk({tag, "_busy_fall"}, tbusy[k + len], 0);
        end
        chk({tag, "_pops"}, pops, sent.size());
        foreach (popped[i])
            if (i < sent.size()) chk($sformatf("%s_pop%0d", tag, i), popped[i], sent[i]);
        chk({tag, "_re_empty"}, bad_empty, 0);
        chk({tag, "_re_dbl"}, dbl, 0);
        chk({tag, "_busy_end"}, busy_o, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pops"}, pops, 0);
        chk({tag, "_txd"}, zeros_from(0), 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_txd_now"}, txd_o, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, mark;

        // Power-on reset
        #2 rst = 1'b0;
        #2;
        chk("rst_txd", txd_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_re", fifo_re, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        trk_clear();
        repeat (40) step(1'b0);
        chk_idle("idle_after_rst");

        // Single byte
        ce_per = 4;
        trk_clear(); push(8'hA5); run_idle("a5", 400); check_frames("a5");

        // Back-to-back pre-loaded bytes
        trk_clear(); push(8'h00); push(8'hFF); run_idle("b2b", 600); check_frames("b2b");

        // Parity-sensitive bytes
        trk_clear(); push(8'h07); run_idle("b07", 400); check_frames("b07");
        trk_clear(); push(8'h03); run_idle("b03", 400); check_frames("b03");

        // Randomised streams with varying baud rates
        for (int unsigned r = 0; r < 4; r++) begin
            ce_per = $urandom_range(2, 6);
            trk_clear();
            n = $urandom_range(1, 4);
            for (int unsigned j = 0; j < n; j++) push(8'($urandom));
            run_idle($sformatf("rnd%0d", r), 2000);
            check_frames($sformatf("rnd%0d", r));
        end

        // CTS low blocks pops; drop mid-frame keeps frame intact and blocks further pops
        ce_per = 4;
        trk_clear();
        cts_i = 1'b0;
        fq.push_back(8'h3C); fq.push_back(8'($urandom));
        repeat (40) step(1'b0);
        chk("cts_block_pops", pops, 0);
        chk("cts_block_txd", zeros_from(0), 0);
        trk_clear();
        sent.push_back(8'h3C);
        cts_i = 1'b1;
        n = 0;
        while (since_start() < 3 && n < 200) begin step(1'b0); n++; end
        chk("cts_start", n < 200, 1);
        cts_i = 1'b0;
        repeat (15 * ce_per) step(1'b0);
        check_frames("cts_mid");

        // CTS drop right after a pop: the held byte is still sent
        trk_clear();
        sent.push_back(fq[0]);
        cts_i = 1'b1;
        n = 0;
        while (pops == 0 && n < 50) begin step(1'b0); n++; end
        cts_i = 1'b0;
        repeat (15 * ce_per) step(1'b0);
        check_frames("cts_held");
        fq.delete();
        cts_i = 1'b1;

        // clr during data bit 4, clr with a pop pending, clr with a held byte
        trk_clear();
        fq.push_back(8'h5A);
        n = 0;
        while (since_start() < 5 && n < 200) begin step(1'b0); n++; end
        chk("clr_reach", n < 200, 1);
        fq.push_back(8'h81);
        step(1'b1);
        chk("clr_txd", txd_o, 1);
        chk("clr_busy", busy_o, 0);
        mark = ticks.size();
        step(1'b1);
        chk("clr_idle_re", pops, 1);
        step(1'b0);
        chk("clr_pop_held", pops, 2);
        step(1'b1);
        chk("clr_drop_busy", busy_o, 0);
        repeat (15 * ce_per) step(1'b0);
        chk("clr_no_frame", zeros_from(mark), 0);
        chk("clr_re_in_clr", clr_re, 0);
        chk("clr_end_busy", busy_o, 0);

        // Reset mid-frame with a byte still waiting in the FIFO
        trk_clear();
        fq.push_back(8'($urandom)); fq.push_back(8'($urandom));
        n = 0;
        while (since_start() < 4 && n < 200) begin step(1'b0); n++; end
        chk("rst_mid_reach", n < 200, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_txd", txd_o, 1);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_re", fifo_re, 0);
        fq.delete();
        fifo_empty = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        trk_clear();
        repeat (60) step(1'b0);
        chk_idle("idle_after_rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
